// File: rtl/silife_pkg.sv
// Shared state encodings and default widths for the silife step scheduler.
package silife_pkg;

  localparam int unsigned DEF_DIV_WIDTH = 24;
  localparam int unsigned DEF_GEN_WIDTH = 16;

  typedef enum logic [2:0] {
    SCHED_IDLE       = 3'd0,
    SCHED_WAIT_TICK  = 3'd1,
    SCHED_WAIT_READY = 3'd2,
    SCHED_STEP       = 3'd3,
    SCHED_WAIT_FRAME = 3'd4
  } sched_state_e;

endpackage

// File: rtl/silife_interval_timer.sv
// Step-interval counter: counts while enabled, pulses tick when the live interval is reached.
module silife_interval_timer #(
  parameter int unsigned DIV_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] interval,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count;
  logic [DIV_WIDTH-1:0] last;

  // Interval 0 behaves as 1; >= lets a lowered interval end an overshot wait at once.
  assign last = (interval == '0) ? '0 : interval - DIV_WIDTH'(1);
  assign tick = en && (count >= last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else if (en) begin
      count <= count + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/silife_step_scheduler.sv
// Generation step sequencer for the silife grid (free-run, N-generation, single-step).
// Optional watchdog on ready/frame waits: define SILIFE_SCHED_WATCHDOG_EN.
module silife_step_scheduler
  import silife_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = DEF_DIV_WIDTH,
  parameter int unsigned GEN_WIDTH = DEF_GEN_WIDTH
`ifdef SILIFE_SCHED_WATCHDOG_EN
  ,
  parameter int unsigned WDT_CYCLES = 65535
`endif
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_run,
  input  logic                 i_step,
  input  logic                 i_gen_load,
  input  logic [GEN_WIDTH-1:0] i_gen_count,
  input  logic                 i_abort,
  input  logic [DIV_WIDTH-1:0] i_interval,
  input  logic                 i_sync_busy,
  input  logic                 i_wait_frame,
  input  logic                 i_frame_busy,
  output logic                 o_step,
  output logic                 o_frame_req,
  output logic                 o_busy,
  output logic [GEN_WIDTH-1:0] o_gen_remaining,
  output logic [GEN_WIDTH-1:0] o_gen_total
`ifdef SILIFE_SCHED_WATCHDOG_EN
  ,
  output logic                 o_timeout
`endif
);

  sched_state_e         state;
  logic [1:0]           rst_sync;
  logic                 rst_n;
  logic                 tick;
  logic                 ready;
  logic                 abort_all;
  logic                 seen_rise;
  logic [GEN_WIDTH-1:0] remaining;
  logic [GEN_WIDTH-1:0] total;
  logic                 step_q;
  logic                 frame_req_q;

  // Assert asynchronously, release on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end
  assign rst_n = rst_sync[1];

  assign ready = !i_sync_busy && !(i_wait_frame && i_frame_busy);

`ifdef SILIFE_SCHED_WATCHDOG_EN
  logic [31:0] wdt_cnt;
  logic        waiting;
  logic        wdt_fire;

  assign waiting   = (state == SCHED_WAIT_READY) || (state == SCHED_WAIT_FRAME);
  assign wdt_fire  = waiting && (wdt_cnt == 32'(WDT_CYCLES - 1));
  assign abort_all = i_abort || wdt_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_cnt   <= '0;
      o_timeout <= 1'b0;
    end else begin
      wdt_cnt <= (!waiting || abort_all) ? '0 : wdt_cnt + 32'd1;
      if (i_abort) begin
        o_timeout <= 1'b0;
      end else if (wdt_fire) begin
        o_timeout <= 1'b1;
      end
    end
  end
`else
  assign abort_all = i_abort;
`endif

  silife_interval_timer #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state == SCHED_WAIT_TICK),
    .clear   (abort_all),
    .interval(i_interval),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SCHED_IDLE;
      remaining   <= '0;
      total       <= '0;
      step_q      <= 1'b0;
      frame_req_q <= 1'b0;
      seen_rise   <= 1'b0;
    end else begin
      step_q      <= 1'b0;
      frame_req_q <= 1'b0;
      // The grid is already enabled in STEP, so the count survives a coincident abort.
      if (state == SCHED_STEP) begin
        total <= total + GEN_WIDTH'(1);
      end
      if (abort_all) begin
        state     <= SCHED_IDLE;
        remaining <= '0;
        seen_rise <= 1'b0;
      end else begin
        case (state)
          SCHED_IDLE: begin
            if (i_gen_load && (i_gen_count != '0)) begin
              remaining <= i_gen_count;
              state     <= SCHED_WAIT_TICK;
            end else if (i_step) begin
              remaining <= GEN_WIDTH'(1);
              state     <= SCHED_WAIT_TICK;
            end else if (i_run) begin
              state <= SCHED_WAIT_TICK;
            end
          end
          SCHED_WAIT_TICK: begin
            if (tick) state <= SCHED_WAIT_READY;
          end
          SCHED_WAIT_READY: begin
            if (ready) begin
              state  <= SCHED_STEP;
              step_q <= 1'b1;
            end
          end
          SCHED_STEP: begin
            if (remaining != '0) remaining <= remaining - GEN_WIDTH'(1);
            if (i_wait_frame) begin
              state       <= SCHED_WAIT_FRAME;
              frame_req_q <= 1'b1;
              seen_rise   <= 1'b0;
            end else if (i_run || (remaining > GEN_WIDTH'(1))) begin
              state <= SCHED_WAIT_TICK;
            end else begin
              state <= SCHED_IDLE;
            end
          end
          SCHED_WAIT_FRAME: begin
            if (!seen_rise) begin
              if (i_frame_busy) seen_rise <= 1'b1;
            end else if (!i_frame_busy) begin
              seen_rise <= 1'b0;
              state     <= (i_run || (remaining != '0)) ? SCHED_WAIT_TICK : SCHED_IDLE;
            end
          end
          default: state <= SCHED_IDLE;
        endcase
      end
    end
  end

  assign o_step          = step_q;
  assign o_frame_req     = frame_req_q;
  assign o_busy          = (state != SCHED_IDLE);
  assign o_gen_remaining = remaining;
  assign o_gen_total     = total;

endmodule

// File: tb/tb_silife_step_scheduler.sv
// Directed self-checking bench for silife_step_scheduler; cycle indices count negedges after stimulus.
module tb_silife_step_scheduler;

  localparam int DW = 24;
  localparam int GW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          i_run, i_step, i_gen_load, i_abort, i_sync_busy, i_wait_frame, i_frame_busy;
  logic [GW-1:0] i_gen_count;
  logic [DW-1:0] i_interval;
  logic          o_step, o_frame_req, o_busy;
  logic [GW-1:0] o_gen_remaining, o_gen_total;
`ifdef SILIFE_SCHED_WATCHDOG_EN
  logic          o_timeout;
`endif

  int checks = 0;
  int errors = 0;
  int exp_total = 0;

  always #5 clk = ~clk;

  silife_step_scheduler #(
    .DIV_WIDTH(DW),
    .GEN_WIDTH(GW)
`ifdef SILIFE_SCHED_WATCHDOG_EN
    ,
    .WDT_CYCLES(20)
`endif
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_run          (i_run),
    .i_step         (i_step),
    .i_gen_load     (i_gen_load),
    .i_gen_count    (i_gen_count),
    .i_abort        (i_abort),
    .i_interval     (i_interval),
    .i_sync_busy    (i_sync_busy),
    .i_wait_frame   (i_wait_frame),
    .i_frame_busy   (i_frame_busy),
    .o_step         (o_step),
    .o_frame_req    (o_frame_req),
    .o_busy         (o_busy),
    .o_gen_remaining(o_gen_remaining),
    .o_gen_total    (o_gen_total)
`ifdef SILIFE_SCHED_WATCHDOG_EN
    ,
    .o_timeout      (o_timeout)
`endif
  );

  task automatic idle_inputs();
    i_run = 0; i_step = 0; i_gen_load = 0; i_abort = 0; i_sync_busy = 0;
    i_wait_frame = 0; i_frame_busy = 0; i_gen_count = '0; i_interval = 24'd1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 reset_n = 0;
    repeat (2) @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", o_busy); end
    checks++; if (o_step !== 1'b0) begin errors++; $display("FAIL reset_step got %0b want 0", o_step); end
    checks++; if (o_gen_total !== '0) begin errors++; $display("FAIL reset_total got %0d want 0", o_gen_total); end
    reset_n = 1;
    repeat (4) @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %0b want 0", o_busy); end
  endtask

  task automatic test_single_step();
    int first, n, rem6, rem7, busy1, busy7;
    first = -1; n = 0; rem6 = 0; rem7 = 0; busy1 = 0; busy7 = 1;
    i_interval = 24'd4; i_step = 1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      i_step = 0;
      if (o_step) begin n++; if (first < 0) first = i; end
      if (i == 1) busy1 = o_busy;
      if (i == 6) rem6 = o_gen_remaining;
      if (i == 7) begin rem7 = o_gen_remaining; busy7 = o_busy; end
    end
    exp_total += 1;
    checks++; if (first != 6) begin errors++; $display("FAIL single_latency got %0d want 6", first); end
    checks++; if (n != 1) begin errors++; $display("FAIL single_count got %0d want 1", n); end
    checks++; if (busy1 != 1) begin errors++; $display("FAIL single_busy_on got %0d want 1", busy1); end
    checks++; if (rem6 != 1) begin errors++; $display("FAIL single_rem_before got %0d want 1", rem6); end
    checks++; if (rem7 != 0) begin errors++; $display("FAIL single_rem_after got %0d want 0", rem7); end
    checks++; if (busy7 != 0) begin errors++; $display("FAIL single_busy_off got %0d want 0", busy7); end
    checks++; if (o_gen_total !== GW'(exp_total)) begin errors++; $display("FAIL single_total got %0d want %0d", o_gen_total, exp_total); end
  endtask

  task automatic test_gen_load();
    int n, rem7;
    int at [4];
    n = 0; rem7 = 0;
    // A zero count must be ignored.
    i_gen_load = 1; i_gen_count = '0;
    @(negedge clk);
    i_gen_load = 0;
    @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL load_zero_busy got %0b want 0", o_busy); end
    i_interval = 24'd2; i_gen_load = 1; i_gen_count = 16'd3;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      i_gen_load = 0; i_step = 0;
      if (o_step) begin if (n < 4) at[n] = i; n++; end
      if (i == 7) rem7 = o_gen_remaining;
      if (i == 6) i_step = 1;  // ignored outside IDLE
    end
    exp_total += 3;
    checks++; if (n != 3) begin errors++; $display("FAIL load_count got %0d want 3", n); end
    checks++; if (n >= 3 && (at[0] != 4 || at[1] != 8 || at[2] != 12)) begin
      errors++; $display("FAIL load_spacing got %0d,%0d,%0d want 4,8,12", at[0], at[1], at[2]); end
    checks++; if (rem7 != 2) begin errors++; $display("FAIL load_step_ignored got %0d want 2", rem7); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL load_idle got %0b want 0", o_busy); end
    checks++; if (o_gen_total !== GW'(exp_total)) begin errors++; $display("FAIL load_total got %0d want %0d", o_gen_total, exp_total); end
  endtask

  task automatic test_sync_hold();
    int first, n;
    first = -1; n = 0;
    i_interval = 24'd1; i_run = 1; i_sync_busy = 1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (o_step) begin n++; if (first < 0) first = i; end
      if (i == 10) i_sync_busy = 0;
      if (i == 11) i_run = 0;
    end
    exp_total += 1;
    checks++; if (first != 11) begin errors++; $display("FAIL sync_latency got %0d want 11", first); end
    checks++; if (n != 1) begin errors++; $display("FAIL sync_count got %0d want 1", n); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL sync_run_drop got %0b want 0", o_busy); end
  endtask

  task automatic test_frame_wait();
    int ns, nf, busy15;
    int st [3];
    int fr [3];
    ns = 0; nf = 0; busy15 = 1;
    i_interval = 24'd1; i_wait_frame = 1; i_run = 1;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      if (o_step) begin if (ns < 3) st[ns] = i; ns++; end
      if (o_frame_req) begin if (nf < 3) fr[nf] = i; nf++; end
      if (i == 15) busy15 = o_busy;
      if (i == 4 || i == 11) i_frame_busy = 1;
      if (i == 7 || i == 14) i_frame_busy = 0;
      if (i == 10) i_run = 0;
    end
    i_wait_frame = 0;
    exp_total += 2;
    checks++; if (ns != 2 || st[0] != 3 || st[1] != 10) begin
      errors++; $display("FAIL frame_steps got n=%0d at %0d,%0d want n=2 at 3,10", ns, st[0], st[1]); end
    checks++; if (nf != 2 || fr[0] != 4 || fr[1] != 11) begin
      errors++; $display("FAIL frame_req got n=%0d at %0d,%0d want n=2 at 4,11", nf, fr[0], fr[1]); end
    checks++; if (busy15 != 0) begin errors++; $display("FAIL frame_idle got %0d want 0", busy15); end
  endtask

  task automatic test_abort();
    int n, rem2, rem4, busy4, tot4, first;
    n = 0; rem2 = 0; rem4 = 1; busy4 = 1;
    i_interval = 24'd8; i_gen_load = 1; i_gen_count = 16'd5;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      i_gen_load = 0;
      if (o_step) n++;
      if (i == 2) rem2 = o_gen_remaining;
      if (i == 4) begin rem4 = o_gen_remaining; busy4 = o_busy; end
      i_abort = (i == 3);
    end
    checks++; if (rem2 != 5) begin errors++; $display("FAIL abort_loaded got %0d want 5", rem2); end
    checks++; if (busy4 != 0) begin errors++; $display("FAIL abort_idle got %0d want 0", busy4); end
    checks++; if (rem4 != 0) begin errors++; $display("FAIL abort_rem got %0d want 0", rem4); end
    checks++; if (n != 0) begin errors++; $display("FAIL abort_no_step got %0d want 0", n); end
    // Abort coincident with STEP: pulse completes and is counted.
    n = 0; first = -1; busy4 = 1; rem4 = 1; tot4 = 0;
    i_interval = 24'd1; i_gen_load = 1; i_gen_count = 16'd2;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      i_gen_load = 0;
      if (o_step) begin n++; if (first < 0) first = i; end
      if (i == 4) begin rem4 = o_gen_remaining; busy4 = o_busy; tot4 = o_gen_total; end
      i_abort = (i == 3);
    end
    exp_total += 1;
    checks++; if (first != 3 || n != 1) begin errors++; $display("FAIL abort_step got n=%0d at %0d want n=1 at 3", n, first); end
    checks++; if (busy4 != 0 || rem4 != 0) begin errors++; $display("FAIL abort_step_idle got busy=%0d rem=%0d want 0 0", busy4, rem4); end
    checks++; if (tot4 != exp_total) begin errors++; $display("FAIL abort_step_total got %0d want %0d", tot4, exp_total); end
  endtask

  task automatic test_interval_edges();
    int first;
    first = -1;
    i_interval = 24'd0; i_step = 1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      i_step = 0;
      if (o_step && first < 0) first = i;
    end
    checks++; if (first != 3) begin errors++; $display("FAIL interval_zero got %0d want 3", first); end
    first = -1;
    i_interval = 24'd10; i_step = 1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      i_step = 0;
      if (o_step && first < 0) first = i;
      if (i == 5) i_interval = 24'd2;
    end
    exp_total += 2;
    checks++; if (first != 7) begin errors++; $display("FAIL interval_live got %0d want 7", first); end
    checks++; if (o_gen_total !== GW'(exp_total)) begin errors++; $display("FAIL interval_total got %0d want %0d", o_gen_total, exp_total); end
  endtask

  task automatic test_reset_mid_frame();
    i_interval = 24'd1; i_wait_frame = 1; i_run = 1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 4) i_frame_busy = 1;
    end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL rst_frame_busy_before got %0b want 1", o_busy); end
    #2 reset_n = 0;
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy got %0b want 0", o_busy); end
    checks++; if (o_gen_total !== '0) begin errors++; $display("FAIL rst_async_total got %0d want 0", o_gen_total); end
    checks++; if (o_step !== 1'b0 || o_frame_req !== 1'b0) begin
      errors++; $display("FAIL rst_async_pulses got %0b%0b want 00", o_step, o_frame_req); end
    exp_total = 0;
    idle_inputs();
    @(negedge clk);
    reset_n = 1;
    repeat (4) @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_release_busy got %0b want 0", o_busy); end
  endtask

`ifdef SILIFE_SCHED_WATCHDOG_EN
  task automatic test_watchdog();
    int seen, busy_at;
    seen = -1; busy_at = 1;
    i_interval = 24'd1; i_run = 1; i_sync_busy = 1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (o_timeout && seen < 0) begin seen = i; busy_at = o_busy; i_run = 0; end
    end
    checks++; if (seen < 0) begin errors++; $display("FAIL wdt_timeout got none want set"); end
    checks++; if (busy_at != 0) begin errors++; $display("FAIL wdt_abort got busy=%0d want 0", busy_at); end
    i_abort = 1;
    @(negedge clk);
    i_abort = 0;
    checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL wdt_clear got %0b want 0", o_timeout); end
    idle_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_single_step();
    test_gen_load();
    test_sync_hold();
    test_frame_wait();
    test_abort();
    test_interval_edges();
    test_reset_mid_frame();
`ifdef SILIFE_SCHED_WATCHDOG_EN
    test_watchdog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
